decimal_to_bin: RTL and testbench

DECIMAL_TO_BIN -- requirements
Module: decimal_to_bin

---
 rtl/scoreboard_pkg.sv | 20 ++
 rtl/mul10_add.sv | 17 +
 rtl/decimal_to_bin.sv | 112 +++++++++++
 tb/tb_decimal_to_bin.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the BCD-entry to binary converter.
package scoreboard_pkg;

    // Entry FSM: no digits, partial entry, full entry, result presented.
    typedef enum logic [1:0] {
        StEmpty,
        StEntry,
        StFull,
        StHold
    } state_e;

    localparam int unsigned DIGIT_MAX = 9;
    localparam int unsigned BIN_W     = 8;

    // True when the nibble is a legal decimal digit.
    function automatic logic is_bcd(input logic [3:0] digit);
        return 32'(digit) <= DIGIT_MAX;
    endfunction

endpackage

// File: rtl/mul10_add.sv
// Combinational acc*10 + digit built from two shifts and adds, wrapping at BIN_W bits.
module mul10_add
    import scoreboard_pkg::*;
(
    input  logic [BIN_W-1:0] acc_i,
    input  logic [3:0]       digit_i,
    output logic [BIN_W-1:0] result_o
);

    logic [BIN_W-1:0] acc_x8;
    logic [BIN_W-1:0] acc_x2;

    assign acc_x8   = acc_i << 3;
    assign acc_x2   = acc_i << 1;
    assign result_o = acc_x8 + acc_x2 + {{(BIN_W - 4){1'b0}}, digit_i};

endmodule

// File: rtl/decimal_to_bin.sv
// Accumulates up to MAX_DIGITS BCD digits (MSD first) and presents the binary value
// through a valid/ready handshake once the entry is committed.
module decimal_to_bin
    import scoreboard_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [3:0]       digit_i,
    input  logic             digit_valid_i,
    output logic             digit_ready_o,
    input  logic             commit_i,
    input  logic             clear_i,
    output logic [BIN_W-1:0] bin_o,
    output logic             bin_valid_o,
    input  logic             bin_ready_i,
    output logic [1:0]       digit_count_o,
    output logic             error_o
);

    localparam logic [1:0] MaxCount = 2'(MAX_DIGITS);

    state_e           state_q;
    logic [BIN_W-1:0] acc_q;
    logic [1:0]       count_q;
    logic [BIN_W-1:0] bin_q;
    logic             bin_valid_q;
    logic             error_q;

    logic [BIN_W-1:0] acc_mac;
    logic [BIN_W-1:0] acc_next;
    logic [1:0]       count_inc;
    logic             digit_ok;
    logic             digit_take;

    mul10_add u_mul10_add (
        .acc_i    (acc_q),
        .digit_i  (digit_i),
        .result_o (acc_mac)
    );

    // Digit acceptance and the value a same-cycle commit would capture.
    assign digit_ok   = is_bcd(digit_i);
    assign digit_take = digit_valid_i && digit_ready_o && digit_ok;
    assign acc_next   = digit_take ? acc_mac : acc_q;
    assign count_inc  = count_q + 2'd1;

    assign digit_ready_o = (state_q == StEmpty) || (state_q == StEntry);
    assign bin_o         = bin_q;
    assign bin_valid_o   = bin_valid_q;
    assign digit_count_o = count_q;
    assign error_o       = error_q;

    // Entry FSM with registered result, count and sticky error; clear overrides everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StEmpty;
            acc_q       <= '0;
            count_q     <= '0;
            bin_q       <= '0;
            bin_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else if (clear_i) begin
            state_q     <= StEmpty;
            acc_q       <= '0;
            count_q     <= '0;
            bin_q       <= '0;
            bin_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StEmpty, StEntry: begin
                    if (digit_valid_i) begin
                        if (digit_ok) begin
                            acc_q   <= acc_mac;
                            count_q <= count_inc;
                            state_q <= (count_inc == MaxCount) ? StFull : StEntry;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                    // An empty entry has nothing to commit.
                    if (commit_i && (state_q == StEntry)) begin
                        state_q     <= StHold;
                        bin_q       <= acc_next;
                        bin_valid_q <= 1'b1;
                    end
                end
                StFull: begin
                    if (commit_i) begin
                        state_q     <= StHold;
                        bin_q       <= acc_q;
                        bin_valid_q <= 1'b1;
                    end
                end
                StHold: begin
                    if (bin_ready_i) begin
                        state_q     <= StEmpty;
                        acc_q       <= '0;
                        count_q     <= '0;
                        bin_q       <= '0;
                        bin_valid_q <= 1'b0;
                        error_q     <= 1'b0;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

endmodule

// File: tb/tb_decimal_to_bin.sv
// Self-checking bench for decimal_to_bin: directed scenarios then randomized traffic,
// all compared against a digit-list reference model.
module tb_decimal_to_bin;

    localparam int unsigned MaxDigits = 2;

    logic       clk_i;
    logic       rst_ni;
    logic [3:0] digit_i;
    logic       digit_valid_i;
    logic       digit_ready_o;
    logic       commit_i;
    logic       clear_i;
    logic [7:0] bin_o;
    logic       bin_valid_o;
    logic       bin_ready_i;
    logic [1:0] digit_count_o;
    logic       error_o;

    int n_tests;
    int n_fail;

    // Reference model: the entry is a list of decimal digits plus a held result.
    int m_digits[$];
    bit m_hold;
    int m_bin;
    bit m_err;

    decimal_to_bin #(
        .MAX_DIGITS (MaxDigits)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .digit_i       (digit_i),
        .digit_valid_i (digit_valid_i),
        .digit_ready_o (digit_ready_o),
        .commit_i      (commit_i),
        .clear_i       (clear_i),
        .bin_o         (bin_o),
        .bin_valid_o   (bin_valid_o),
        .bin_ready_i   (bin_ready_i),
        .digit_count_o (digit_count_o),
        .error_o       (error_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic int digits_value();
        int v = 0;
        foreach (m_digits[i]) v = v * 10 + m_digits[i];
        return v;
    endfunction

    task automatic model_reset();
        m_digits.delete();
        m_hold = 1'b0;
        m_bin  = 0;
        m_err  = 1'b0;
    endtask

    task automatic model_edge(input bit v, input int d, input bit c, input bit cl, input bit r);
        int n_before;
        n_before = m_digits.size();
        if (cl) begin
            model_reset();
        end else if (m_hold) begin
            if (r) model_reset();
        end else begin
            if (v && n_before < MaxDigits) begin
                if (d > 9) m_err = 1'b1;
                else m_digits.push_back(d);
            end
            if (c && n_before > 0) begin
                m_hold = 1'b1;
                m_bin  = digits_value();
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        assert (act === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit exp_ready;
        exp_ready = !m_hold && (m_digits.size() < MaxDigits);
        chk({tag, "/ready"}, 8'(digit_ready_o), 8'(exp_ready));
        chk({tag, "/count"}, 8'(digit_count_o), 8'(m_digits.size()));
        chk({tag, "/valid"}, 8'(bin_valid_o), 8'(m_hold));
        chk({tag, "/bin"}, bin_o, m_hold ? 8'(m_bin) : 8'd0);
        chk({tag, "/error"}, 8'(error_o), 8'(m_err));
    endtask

    // Present inputs, take one rising edge, advance the model, then sample.
    task automatic cycle(input string tag, input bit v, input int d, input bit c, input bit cl,
                         input bit r);
        digit_valid_i = v;
        digit_i       = 4'(d);
        commit_i      = c;
        clear_i       = cl;
        bin_ready_i   = r;
        @(posedge clk_i);
        model_edge(v, d, c, cl, r);
        #1;
        check_all(tag);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst_ni        = 1'b0;
        digit_i       = '0;
        digit_valid_i = 1'b0;
        commit_i      = 1'b0;
        clear_i       = 1'b0;
        bin_ready_i   = 1'b0;
        model_reset();
        #2;
        check_all("reset");

        // First edge after reset release accepts a digit.
        @(negedge clk_i);
        rst_ni = 1'b1;
        cycle("d4", 1, 4, 0, 0, 0);
        cycle("d2", 1, 2, 0, 0, 0);
        cycle("commit42", 0, 0, 1, 0, 0);
        chk("bin42", bin_o, 8'd42);
        cycle("ready42", 0, 0, 0, 0, 1);

        // Held result must stay stable until the consumer is ready.
        cycle("d7", 1, 7, 0, 0, 0);
        cycle("commit7", 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle("hold7", 0, 0, 0, 0, 0);
            chk("stable7", bin_o, 8'd7);
        end
        cycle("ready7", 0, 0, 0, 0, 1);

        // Third digit in FULL is ignored without error.
        cycle("d9a", 1, 9, 0, 0, 0);
        cycle("d9b", 1, 9, 0, 0, 0);
        cycle("d5full", 1, 5, 0, 0, 0);
        cycle("commit99", 0, 0, 1, 0, 0);
        chk("bin99", bin_o, 8'd99);
        cycle("ready99", 0, 0, 0, 0, 1);

        // Illegal digit sets sticky error, handshake clears it.
        cycle("dC", 1, 12, 0, 0, 0);
        cycle("d3", 1, 3, 0, 0, 0);
        cycle("commit3", 0, 0, 1, 0, 0);
        chk("err3", 8'(error_o), 8'd1);
        cycle("ready3", 0, 0, 0, 0, 1);
        chk("errclr", 8'(error_o), 8'd0);

        // Digit taken with commit is included; clear in HOLD drops the result.
        cycle("d0", 1, 0, 0, 0, 0);
        cycle("d1commit", 1, 1, 1, 0, 0);
        chk("bin1", bin_o, 8'd1);
        cycle("clearhold", 0, 0, 0, 1, 0);

        // Clear discards a same-cycle digit and commit.
        cycle("d6", 1, 6, 0, 0, 0);
        cycle("clearmix", 1, 8, 1, 1, 0);

        // Asynchronous reset mid-entry zeroes outputs without a clock edge.
        cycle("d5", 1, 5, 0, 0, 0);
        @(negedge clk_i);
        rst_ni = 1'b0;
        model_reset();
        #1;
        check_all("asyncrst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        cycle("postrst", 1, 8, 0, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit v;
            bit c;
            bit cl;
            bit r;
            int d;
            v  = ($urandom_range(0, 1) == 1);
            d  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15))
                                             : int'($urandom_range(0, 9));
            c  = ($urandom_range(0, 4) == 0);
            cl = ($urandom_range(0, 29) == 0);
            r  = ($urandom_range(0, 2) == 0);
            cycle("rand", v, d, c, cl, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
